// File: rtl/arbitro_entrada_registrador.sv
// arbitro_entrada_registrador: N-channel write arbiter feeding one registered register-file write port.
// Define ARBITRO_ROUND_ROBIN_EN for round-robin selection; otherwise the lowest valid index wins.
module arbitro_entrada_registrador #(
   parameter int NUM_CANAIS   = 2,
   parameter int LARGURA_END  = 5,
   parameter int LARGURA_DADO = 32,
   localparam int LC = (NUM_CANAIS > 1) ? $clog2(NUM_CANAIS) : 1
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [NUM_CANAIS-1:0]              req_valido,
   input  logic [NUM_CANAIS*LARGURA_END-1:0]  req_end,
   input  logic [NUM_CANAIS*LARGURA_DADO-1:0] req_dado,
   output logic [NUM_CANAIS-1:0]              req_pronto,
   output logic                               escrita_valida,
   input  logic                               escrita_pronto,
   output logic [LARGURA_END-1:0]             escrita_end,
   output logic [LARGURA_DADO-1:0]            escrita_dado,
   output logic [LC-1:0]                      escrita_canal
);
   logic                    carga, achou, transf;
   logic [LC-1:0]           sel;
   logic [LARGURA_END-1:0]  end_sel;
   logic [LARGURA_DADO-1:0] dado_sel;
   logic                    valida_q, valida_d;
   logic [LARGURA_END-1:0]  end_q, end_d;
   logic [LARGURA_DADO-1:0] dado_q, dado_d;
   logic [LC-1:0]           canal_q, canal_d;
   assign carga  = !valida_q || escrita_pronto;
   assign transf = carga && achou;
`ifdef ARBITRO_ROUND_ROBIN_EN
   logic [LC-1:0] ptr_q, ptr_d;
   // search starts one past the last granted channel and wraps
   always_comb begin
      sel   = '0;
      achou = 1'b0;
      for (int k = 1; k <= NUM_CANAIS; k++) begin
         if (!achou && req_valido[(int'(ptr_q) + k) % NUM_CANAIS]) begin
            achou = 1'b1;
            sel   = LC'((int'(ptr_q) + k) % NUM_CANAIS);
         end
      end
      ptr_d = transf ? sel : ptr_q;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) ptr_q <= LC'(NUM_CANAIS - 1);
      else       ptr_q <= ptr_d;
   end
`else
   always_comb begin
      sel   = '0;
      achou = 1'b0;
      for (int k = NUM_CANAIS - 1; k >= 0; k--) begin
         if (req_valido[k]) begin
            achou = 1'b1;
            sel   = LC'(k);
         end
      end
   end
`endif
   assign end_sel  = req_end[int'(sel)*LARGURA_END +: LARGURA_END];
   assign dado_sel = req_dado[int'(sel)*LARGURA_DADO +: LARGURA_DADO];
   always_comb begin
      valida_d   = carga ? achou : valida_q;
      end_d      = transf ? end_sel : end_q;
      dado_d     = transf ? dado_sel : dado_q;
      canal_d    = transf ? sel : canal_q;
      req_pronto = (transf && !reset) ? (NUM_CANAIS'(1) << sel) : '0;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valida_q <= 1'b0;
         end_q    <= '0;
         dado_q   <= '0;
         canal_q  <= '0;
      end else begin
         valida_q <= valida_d;
         end_q    <= end_d;
         dado_q   <= dado_d;
         canal_q  <= canal_d;
      end
   end
   assign escrita_valida = valida_q;
   assign escrita_end    = end_q;
   assign escrita_dado   = dado_q;
   assign escrita_canal  = canal_q;
endmodule

// File: tb/tb_arbitro_entrada_registrador.sv
// tb_arbitro_entrada_registrador: directed vector table plus hand sequences for stall, back-to-back,
// reset mid-operation and a 4-channel/64-bit instance; expectations follow ARBITRO_ROUND_ROBIN_EN.
module tb_arbitro_entrada_registrador;
`ifdef ARBITRO_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;
   logic [1:0]  rv, rp;
   logic [9:0]  re;
   logic [63:0] rd;
   logic        ep, ev, ec;
   logic [4:0]  ee;
   logic [31:0] ed;
   logic [3:0]   wv, wrp;
   logic [19:0]  we;
   logic [255:0] wd;
   logic         wp, wev;
   logic [4:0]   wee;
   logic [63:0]  wed;
   logic [1:0]   wec;
   int n_cmp = 0;
   int n_bad = 0;
   arbitro_entrada_registrador dut (
      .clock(clock), .reset(reset), .req_valido(rv), .req_end(re), .req_dado(rd),
      .req_pronto(rp), .escrita_valida(ev), .escrita_pronto(ep), .escrita_end(ee),
      .escrita_dado(ed), .escrita_canal(ec)
   );
   arbitro_entrada_registrador #(.NUM_CANAIS(4), .LARGURA_END(5), .LARGURA_DADO(64)) dut_w (
      .clock(clock), .reset(reset), .req_valido(wv), .req_end(we), .req_dado(wd),
      .req_pronto(wrp), .escrita_valida(wev), .escrita_pronto(wp), .escrita_end(wee),
      .escrita_dado(wed), .escrita_canal(wec)
   );
   typedef struct packed {
      logic [1:0]  v;
      logic [4:0]  e1, e0;
      logic [31:0] d1, d0;
      logic        p;
      logic [1:0]  rp;
      logic        ev;
      logic [4:0]  ee;
      logic [31:0] ed;
      logic        ec;
   } vec_t;
   vec_t tbl [10];
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic step_rp(input string name, input logic [1:0] exp);
      #2 chk(name, rp, exp);
      @(posedge clock);
      #1;
   endtask
   task automatic chk_out(input string name, input logic v, input logic [4:0] e, input logic [31:0] d, input logic c);
      chk({name, "_valida"}, ev, v);
      chk({name, "_end"}, ee, e);
      chk({name, "_dado"}, ed, d);
      chk({name, "_canal"}, ec, c);
   endtask
   initial begin
      rv = '0; re = '0; rd = '0; ep = 1'b0;
      wv = '0; we = '0; wd = '0; wp = 1'b0;
      tbl[0] = '{2'b01, 5'd0, 5'd3, 32'h0,  32'hA5, 1'b1, 2'b01, 1'b1, 5'd3, 32'hA5, 1'b0};
      tbl[1] = '{2'b00, 5'd0, 5'd3, 32'h0,  32'hA5, 1'b0, 2'b00, 1'b1, 5'd3, 32'hA5, 1'b0};
      tbl[2] = '{2'b10, 5'd9, 5'd3, 32'h5A, 32'hA5, 1'b0, 2'b00, 1'b1, 5'd3, 32'hA5, 1'b0};
      tbl[3] = '{2'b10, 5'd9, 5'd3, 32'h5A, 32'hA5, 1'b1, 2'b10, 1'b1, 5'd9, 32'h5A, 1'b1};
      tbl[4] = '{2'b00, 5'd9, 5'd3, 32'h5A, 32'hA5, 1'b1, 2'b00, 1'b0, 5'd9, 32'h5A, 1'b1};
      tbl[5] = '{2'b00, 5'd9, 5'd3, 32'h5A, 32'hA5, 1'b0, 2'b00, 1'b0, 5'd9, 32'h5A, 1'b1};
      tbl[6] = '{2'b10, 5'd9, 5'd3, 32'h5A, 32'hA5, 1'b0, 2'b10, 1'b1, 5'd9, 32'h5A, 1'b1};
      tbl[7] = '{2'b01, 5'd9, 5'd3, 32'h5A, 32'hA5, 1'b0, 2'b00, 1'b1, 5'd9, 32'h5A, 1'b1};
      tbl[8] = '{2'b01, 5'd9, 5'd3, 32'h5A, 32'hA5, 1'b1, 2'b01, 1'b1, 5'd3, 32'hA5, 1'b0};
      tbl[9] = '{2'b00, 5'd9, 5'd3, 32'h5A, 32'hA5, 1'b1, 2'b00, 1'b0, 5'd3, 32'hA5, 1'b0};
      // reset state, with a request present to show req_pronto is masked
      @(posedge clock);
      #1 rv = 2'b01; ep = 1'b1;
      #1 chk_out("reset", 1'b0, 5'd0, 32'h0, 1'b0);
      chk("reset_rp", rp, 2'b00);
      @(negedge clock) reset = 1'b0; rv = 2'b00; ep = 1'b0;
      @(posedge clock);
      #1;
      for (int i = 0; i < 10; i++) begin
         rv = tbl[i].v; re = {tbl[i].e1, tbl[i].e0}; rd = {tbl[i].d1, tbl[i].d0}; ep = tbl[i].p;
         step_rp($sformatf("vec%0d_rp", i), tbl[i].rp);
         chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ee, tbl[i].ed, tbl[i].ec);
      end
      // stall with both channels waiting
      rv = 2'b01; re = {5'd9, 5'd3}; rd = {32'h5A, 32'hA5}; ep = 1'b1;
      step_rp("stall_load_rp", 2'b01);
      chk_out("stall_load", 1'b1, 5'd3, 32'hA5, 1'b0);
      rv = 2'b11; ep = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step_rp($sformatf("stall%0d_rp", k), 2'b00);
         chk_out($sformatf("stall%0d", k), 1'b1, 5'd3, 32'hA5, 1'b0);
      end
      ep = 1'b1;
      step_rp("stall_grant_rp", RR ? 2'b10 : 2'b01);
      chk_out("stall_grant", 1'b1, RR ? 5'd9 : 5'd3, RR ? 32'h5A : 32'hA5, RR);
      // back-to-back, no bubbles
      for (int k = 0; k < 6; k++) begin
         step_rp($sformatf("b2b%0d_rp", k), (RR && k % 2 == 1) ? 2'b10 : 2'b01);
         chk($sformatf("b2b%0d_valida", k), ev, 1'b1);
         chk($sformatf("b2b%0d_canal", k), ec, RR ? k % 2 : 0);
      end
      rv = 2'b00;
      step_rp("drain_rp", 2'b00);
      chk_out("drain", 1'b0, RR ? 5'd9 : 5'd3, RR ? 32'h5A : 32'hA5, RR);
      // asynchronous reset while a write is pending
      rv = 2'b10; re = {5'd7, 5'd3};
      step_rp("rstop_load_rp", 2'b10);
      chk_out("rstop_load", 1'b1, 5'd7, 32'h5A, 1'b1);
      rv = 2'b11; ep = 1'b0;
      #2 reset = 1'b1;
      #1 chk_out("rstop_async", 1'b0, 5'd0, 32'h0, 1'b0);
      chk("rstop_async_rp", rp, 2'b00);
      @(negedge clock) reset = 1'b0; ep = 1'b1;
      #1 chk("rstop_first_rp", rp, 2'b01);
      @(posedge clock);
      #1 chk_out("rstop_first", 1'b1, 5'd3, 32'hA5, 1'b0);
      rv = 2'b00;
      // 4-channel 64-bit instance, channels 1 and 3 requesting
      wv = 4'b1010; wp = 1'b1;
      we[5 +: 5] = 5'd11; we[15 +: 5] = 5'd13;
      wd[64 +: 64] = 64'h1111_0000_0000_0001; wd[192 +: 64] = 64'h3333_0000_0000_0003;
      for (int k = 0; k < 4; k++) begin
         #2 chk($sformatf("wide%0d_rp", k), wrp, (RR && k % 2 == 1) ? 4'b1000 : 4'b0010);
         @(posedge clock);
         #1 chk($sformatf("wide%0d_valida", k), wev, 1'b1);
         chk($sformatf("wide%0d_canal", k), wec, (RR && k % 2 == 1) ? 2'd3 : 2'd1);
         chk($sformatf("wide%0d_end", k), wee, (RR && k % 2 == 1) ? 5'd13 : 5'd11);
         chk($sformatf("wide%0d_dado", k), wed, (RR && k % 2 == 1) ? 64'h3333_0000_0000_0003 : 64'h1111_0000_0000_0001);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
